// File: rtl/regfile_writer.sv
// regfile_writer: owns the register-file write port, merging ALU results (port A) with FIFO-buffered load/mul results (port B).
// Define REGFILE_WRITER_STARVE_EN to build the starvation guard that forces the FIFO head through after STARVE_MAX losses.
module regfile_writer #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        we3,
  output logic [4:0]  wa3,
  output logic [31:0] wd3,
  output logic        busy,
  input  logic [4:0]  q_addr,
  output logic        q_pending
);

  localparam int AW = $clog2(DEPTH);

  logic [4:0]    fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   count;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          a_grant;
  logic          force_b;

  assign wr_idx  = wr_ptr[AW-1:0];
  assign rd_idx  = rd_ptr[AW-1:0];
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

  // Writes to x0 are swallowed at the input so they never occupy a slot.
  assign b_ready = !full && !reset;
  assign push    = b_valid && b_ready && (b_addr != 5'd0);

`ifdef REGFILE_WRITER_STARVE_EN
  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam logic [SCW-1:0] SC_MAX = SCW'(STARVE_MAX);

  logic [SCW-1:0] sc;

  always_ff @(posedge clk) begin
    if (reset || empty || pop) begin
      sc <= '0;
    end else if (a_grant && (sc < SC_MAX)) begin
      sc <= sc + SCW'(1);
    end
  end

  assign force_b = (sc == SC_MAX) && !empty;
`else
  assign force_b = 1'b0;
`endif

  // An A beat aimed at x0 is accepted but counts as idle, letting the FIFO head use the slot.
  assign a_ready = !force_b && !reset;
  assign a_grant = a_valid && a_ready && (a_addr != 5'd0);
  assign pop     = !a_grant && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        fifo_addr[wr_idx] <= b_addr;
        fifo_data[wr_idx] <= b_data;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
    end else if (a_grant) begin
      we3 <= 1'b1;
      wa3 <= a_addr;
      wd3 <= a_data;
    end else if (pop) begin
      we3 <= 1'b1;
      wa3 <= fifo_addr[rd_idx];
      wd3 <= fifo_data[rd_idx];
    end else begin
      we3 <= 1'b0;
    end
  end

  assign busy = !empty || we3;

  // Hazard query scans only live FIFO slots (head onward) plus the output register.
  always_comb begin
    q_pending = 1'b0;
    if (q_addr != 5'd0) begin
      if (we3 && (wa3 == q_addr)) begin
        q_pending = 1'b1;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (((AW+1)'(k) < count) && (fifo_addr[rd_idx + AW'(k)] == q_addr)) begin
          q_pending = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_writer.sv
// tb_regfile_writer: random and directed stimulus for regfile_writer, checked against a queue-based reference model.
// Honours REGFILE_WRITER_STARVE_EN the same way as the design.
module tb_regfile_writer;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [4:0]  a_addr = '0;
  logic [31:0] a_data = '0;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [4:0]  b_addr = '0;
  logic [31:0] b_data = '0;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic        busy;
  logic [4:0]  q_addr = '0;
  logic        q_pending;

  regfile_writer #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .we3(we3), .wa3(wa3), .wd3(wd3), .busy(busy),
    .q_addr(q_addr), .q_pending(q_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  // Reference model: pending B writes as a queue, losses-in-a-row counter, and the write-port register.
  entry_t      mq[$];
  int          m_losses = 0;
  logic        m_we = 1'b0;
  logic [4:0]  m_wa = '0;
  logic [31:0] m_wd = '0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_pending(input logic [4:0] qa);
    logic hit;
    hit = 1'b0;
    if (qa != 5'd0) begin
      if (m_we && m_wa == qa) hit = 1'b1;
      foreach (mq[i]) if (mq[i].addr == qa) hit = 1'b1;
    end
    return hit;
  endfunction

  // One clock cycle: check registered outputs, drive inputs, check combinational outputs, advance the model.
  task automatic applyStimulus(input logic rst, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                               input logic bv, input logic [4:0] ba, input logic [31:0] bd, input logic [4:0] qa);
    logic exp_force, exp_ar, exp_br, grant_a, drain_b;
    @(negedge clk);
    checkOutput("we3", {31'd0, we3}, {31'd0, m_we});
    checkOutput("wa3", {27'd0, wa3}, {27'd0, m_wa});
    checkOutput("wd3", wd3, m_wd);
    checkOutput("busy", {31'd0, busy}, {31'd0, (m_we || mq.size() != 0)});
    reset = rst; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd; q_addr = qa;
    #1;
`ifdef REGFILE_WRITER_STARVE_EN
    exp_force = (m_losses == STARVE_MAX) && (mq.size() != 0);
`else
    exp_force = 1'b0;
`endif
    exp_ar = !exp_force && !rst;
    exp_br = (mq.size() < DEPTH) && !rst;
    checkOutput("a_ready", {31'd0, a_ready}, {31'd0, exp_ar});
    checkOutput("b_ready", {31'd0, b_ready}, {31'd0, exp_br});
    checkOutput("q_pending", {31'd0, q_pending}, {31'd0, model_pending(qa)});
    if (rst) begin
      mq.delete();
      m_losses = 0;
      m_we = 1'b0; m_wa = '0; m_wd = '0;
    end else begin
      grant_a = av && exp_ar && (aa != 5'd0);
      drain_b = !grant_a && (mq.size() != 0);
      if (mq.size() == 0 || drain_b) m_losses = 0;
      else if (grant_a && m_losses < STARVE_MAX) m_losses++;
      if (grant_a) begin
        m_we = 1'b1; m_wa = aa; m_wd = ad;
      end else if (drain_b) begin
        m_we = 1'b1; m_wa = mq[0].addr; m_wd = mq[0].data;
        void'(mq.pop_front());
      end else begin
        m_we = 1'b0;
      end
      if (bv && exp_br && ba != 5'd0) mq.push_back({ba, bd});
    end
  endtask

  initial begin
    logic [31:0] r;
    // Reset held for a couple of cycles.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 5'd3, 32'h1, 1, 5'd4, 32'h2, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // A-only write to x5, then an A write to x0 which must not pulse we3.
    applyStimulus(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 5'd5);
    @(posedge clk); #1;
    checkOutput("a_x5_we3", {31'd0, we3}, 32'd1);
    checkOutput("a_x5_wa3", {27'd0, wa3}, 32'd5);
    checkOutput("a_x5_wd3", wd3, 32'hDEADBEEF);
    applyStimulus(0, 1, 5'd0, 32'h12345678, 0, 0, 0, 5'd0);
    @(posedge clk); #1;
    checkOutput("a_x0_we3", {31'd0, we3}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // FIFO fill with A continuously busy on x9.
    for (int i = 1; i <= 4; i++)
      applyStimulus(0, 1, 5'd9, 32'hA000_0000 + i, 1, 5'(i), 32'hB000_0000 + i, 5'(i));
    for (int i = 0; i < 6; i++)
      applyStimulus(0, 1, 5'd9, 32'hA100_0000 + i, 1, 5'd6, 32'hB100_0000 + i, 5'd1);
    for (int i = 0; i < 12; i++)
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd4);

    // Pending query on x7 through its whole lifetime, with x0 queries mixed in.
    applyStimulus(0, 0, 0, 0, 1, 5'd7, 32'h7777_0007, 5'd0);
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 0, 0, 0, 0, 0, 0, (i == 2) ? 5'd0 : 5'd7);

    // Push/pop together at occupancy 2; order x1 then x2 must survive.
    applyStimulus(0, 1, 5'd20, 32'h20, 1, 5'd1, 32'hC1, 5'd1);
    applyStimulus(0, 1, 5'd21, 32'h21, 1, 5'd2, 32'hC2, 5'd2);
    applyStimulus(0, 0, 0, 0, 1, 5'd3, 32'hC3, 5'd2);
    applyStimulus(0, 0, 0, 0, 1, 5'd4, 32'hC4, 5'd3);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd4);

    // Reset with three entries queued.
    applyStimulus(0, 1, 5'd9, 32'h1, 1, 5'd11, 32'hD1, 0);
    applyStimulus(0, 1, 5'd9, 32'h2, 1, 5'd12, 32'hD2, 0);
    applyStimulus(0, 1, 5'd9, 32'h3, 1, 5'd13, 32'hD3, 5'd12);
    applyStimulus(1, 1, 5'd9, 32'h4, 1, 5'd14, 32'hD4, 5'd12);
    @(posedge clk); #1;
    checkOutput("rst_mid_we3", {31'd0, we3}, 32'd0);
    checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd12);

    // Random traffic over a small address range so queries hit in-flight writes.
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      applyStimulus(($urandom_range(0, 79) == 0),
                    r[0] | r[1], 5'($urandom_range(0, 7)), $urandom,
                    r[2] | r[3], 5'($urandom_range(0, 7)), $urandom,
                    5'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
